// File: rtl/pipe_skid.sv
// Two-entry valid/ready register slice: main drives the output, skid absorbs the
// one extra beat accepted while the consumer stalls, so in_rdy can be registered.
module pipe_skid #(
    parameter int unsigned  W    = 8,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         in_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    input  logic         out_rdy
);

    typedef enum logic [1:0] {
        EMPTY,
        BUSY,
        FULL
    } state_t;

    state_t       state;
    state_t       next_state;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         main_en;
    logic         main_sel_skid;
    logic         skid_en;
    logic         push;
    logic         pop;

    assign push    = in_vld & in_rdy;
    assign pop     = out_vld & out_rdy;
    assign out_dat = main_q;

    always_comb begin
        next_state    = state;
        main_en       = 1'b0;
        main_sel_skid = 1'b0;
        skid_en       = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    next_state = BUSY;
                    main_en    = 1'b1;
                end
            end
            BUSY: begin
                if (push && pop) begin
                    main_en = 1'b1;
                end else if (push) begin
                    next_state = FULL;
                    skid_en    = 1'b1;
                end else if (pop) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
                // in_rdy is low here, so in_vld cannot reach either register
                if (pop) begin
                    next_state    = BUSY;
                    main_en       = 1'b1;
                    main_sel_skid = 1'b1;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    // Handshake flags are registered copies of the decoded next state.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state   <= EMPTY;
            in_rdy  <= 1'b1;
            out_vld <= 1'b0;
        end else begin
            state   <= next_state;
            in_rdy  <= (next_state != FULL);
            out_vld <= (next_state != EMPTY);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            main_q <= INIT;
        end else if (main_en) begin
            main_q <= main_sel_skid ? skid_q : in_dat;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            skid_q <= INIT;
        end else if (skid_en) begin
            skid_q <= in_dat;
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (arst)
        !(state == FULL && push));

    a_no_pop_empty: assert property (@(posedge clk) disable iff (arst)
        !(state == EMPTY && pop));

    a_occupancy: assert property (@(posedge clk) disable iff (arst)
        (in_rdy == (state != FULL)) && (out_vld == (state != EMPTY)));

endmodule

// File: tb/tb_pipe_skid.sv
// Bench for pipe_skid: directed vectors at W=8, then random back-pressure at
// W=1 and W=32 checked against a queue model of a two-deep FIFO.
module tb_pipe_skid;

    logic clk;
    logic arst;

    logic        vld8, rdy8_in, ordy8, ovld8;
    logic [7:0]  dat8, odat8;
    logic        vld1, irdy1, ordy1, ovld1;
    logic [0:0]  dat1, odat1;
    logic        vld32, irdy32, ordy32, ovld32;
    logic [31:0] dat32, odat32;

    int checks;
    int failures;

    pipe_skid #(.W(8), .INIT(8'h00)) dut8 (
        .clk(clk), .arst(arst),
        .in_vld(vld8), .in_dat(dat8), .in_rdy(rdy8_in),
        .out_vld(ovld8), .out_dat(odat8), .out_rdy(ordy8)
    );

    pipe_skid #(.W(1)) dut1 (
        .clk(clk), .arst(arst),
        .in_vld(vld1), .in_dat(dat1), .in_rdy(irdy1),
        .out_vld(ovld1), .out_dat(odat1), .out_rdy(ordy1)
    );

    pipe_skid #(.W(32)) dut32 (
        .clk(clk), .arst(arst),
        .in_vld(vld32), .in_dat(dat32), .in_rdy(irdy32),
        .out_vld(ovld32), .out_dat(odat32), .out_rdy(ordy32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       in_vld;
        logic [7:0] in_dat;
        logic       out_rdy;
        logic       exp_in_rdy;
        logic       exp_out_vld;
        logic [7:0] exp_out_dat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic v, input logic [7:0] d, input logic r);
        vld8  = v;
        dat8  = d;
        ordy8 = r;
    endtask

    task automatic check8(input string name, input logic ir, input logic ov, input logic [7:0] od);
        check({name, ".in_rdy"}, {31'b0, rdy8_in}, {31'b0, ir});
        check({name, ".out_vld"}, {31'b0, ovld8}, {31'b0, ov});
        if (ov) check({name, ".out_dat"}, {24'b0, odat8}, {24'b0, od});
    endtask

    vec_t vecs[$];
    logic [31:0] q1[$];
    logic [31:0] q32[$];

    initial begin
        checks   = 0;
        failures = 0;
        arst     = 1'b1;
        drive8(1'b0, 8'h00, 1'b0);
        vld1 = 1'b0; dat1 = 1'b0; ordy1 = 1'b0;
        vld32 = 1'b0; dat32 = '0; ordy32 = 1'b0;
        tick();
        tick();
        check8("reset_state", 1'b1, 1'b0, 8'h00);
        check("reset_state.out_dat", {24'b0, odat8}, 32'h0);
        arst = 1'b0;

        // Reset while FULL: outputs clear immediately, no entry survives
        drive8(1'b1, 8'h11, 1'b0); tick();
        drive8(1'b1, 8'h22, 1'b0); tick();
        check8("rst_fill", 1'b0, 1'b1, 8'h11);
        drive8(1'b0, 8'h00, 1'b0);
        #2 arst = 1'b1;
        #1;
        check8("rst_async", 1'b1, 1'b0, 8'h00);
        check("rst_async.out_dat", {24'b0, odat8}, 32'h0);
        tick();
        arst = 1'b0;
        drive8(1'b1, 8'h33, 1'b0); tick();
        check8("rst_first", 1'b1, 1'b1, 8'h33);
        drive8(1'b0, 8'h00, 1'b1); tick();
        check8("rst_alone", 1'b1, 1'b0, 8'h00);

        // Streaming at full rate
        for (int i = 1; i <= 16; i++) begin
            drive8(1'b1, 8'(i), 1'b1);
            tick();
            check8($sformatf("stream%0d", i), 1'b1, 1'b1, 8'(i));
        end
        drive8(1'b0, 8'h00, 1'b1); tick();
        check8("stream_drain", 1'b1, 1'b0, 8'h00);

        // Skid fill / blocked producer / drain, BUSY push+pop, drain from FULL
        vecs = '{
            '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 8'hA1},
            '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 8'hA1},
            '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hA1},
            '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hA1},
            '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hA1},
            '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hA2},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00},
            '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A},
            '{1'b1, 8'h5B, 1'b1, 1'b1, 1'b1, 8'h5B},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00},
            '{1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 8'h10},
            '{1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 8'h10},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h20},
            '{1'b1, 8'h30, 1'b1, 1'b1, 1'b1, 8'h30},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00}
        };
        foreach (vecs[i]) begin
            drive8(vecs[i].in_vld, vecs[i].in_dat, vecs[i].out_rdy);
            tick();
            check8($sformatf("vec%0d", i), vecs[i].exp_in_rdy, vecs[i].exp_out_vld, vecs[i].exp_out_dat);
        end

        // Random back-pressure at W=1 and W=32 against a two-deep FIFO model
        for (int cyc = 0; cyc < 10000; cyc++) begin
            vld1   = ($urandom_range(0, 3) != 0);
            dat1   = 1'($urandom_range(0, 1));
            ordy1  = ($urandom_range(0, 2) != 0);
            vld32  = ($urandom_range(0, 2) != 0);
            dat32  = $urandom;
            ordy32 = ($urandom_range(0, 3) == 0) ? 1'b0 : ($urandom_range(0, 1) == 1);

            begin
                bit p, o;
                p = vld1 && (q1.size() < 2);
                o = ordy1 && (q1.size() > 0);
                if (o) void'(q1.pop_front());
                if (p) q1.push_back({31'b0, dat1});
                p = vld32 && (q32.size() < 2);
                o = ordy32 && (q32.size() > 0);
                if (o) void'(q32.pop_front());
                if (p) q32.push_back(dat32);
            end

            tick();

            check("w1.in_rdy", {31'b0, irdy1}, {31'b0, (q1.size() < 2)});
            check("w1.out_vld", {31'b0, ovld1}, {31'b0, (q1.size() > 0)});
            if (q1.size() > 0) check("w1.out_dat", {31'b0, odat1}, q1[0]);
            check("w32.in_rdy", {31'b0, irdy32}, {31'b0, (q32.size() < 2)});
            check("w32.out_vld", {31'b0, ovld32}, {31'b0, (q32.size() > 0)});
            if (q32.size() > 0) check("w32.out_dat", odat32, q32[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
